md5_msg_loader: RTL
===================

# md5_msg_loader

- Upstream input stage for `md5_output`; the operator enters a 16-byte message one byte at a time from board switches.
- Each debounced push-button press stores `sw_in` into the next byte slot.
- When all 16 bytes are loaded, the block presents a stable 128-bit `data` word with `start` asserted.
- On the next press it drives a one-cycle `action` strobe to launch the digest.

## Interface
Parameters:
- `MSG_BYTES`, 16: message length in bytes; `data` width is `8*MSG_BYTES`.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a key level change.

Ports:
- `clk`  in  1: single system clock.
- `rst`  in  1: synchronous, active-low reset.
- `sw_in`  in  8: byte value to load.
- `key_in`  in  1: raw push-button, active low, asynchronous to `clk`.
- `clear_in`  in  1: active-high; discards the message and returns to COLLECT.
- `data`  out  128: assembled message; the first byte entered occupies `data[127:120]`.
- `start`  out  1: high while the message is complete (READY and DONE).
- `action`  out  1: one-cycle launch strobe to `md5_output`.
- `byte_cnt`  out  5: number of bytes loaded, 0..16.
- `full`  out  1: `byte_cnt == 16`.

## Operation
Reset (`rst` low at a clock edge):
- `data`=0, `start`=0, `action`=0, `byte_cnt`=0, `full`=0.
- State = COLLECT; debouncer stable level = 1 (released); counters = 0.

Debounce:
- `key_in` passes through a 2-flop synchronizer.
- A counter increments while the synchronized level differs from the stable level, and clears whenever they match.
- When the counter reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
- A 1→0 flip of the stable level generates a one-cycle `press` pulse; releases generate nothing.

States:
- COLLECT:
  - `press`: `data[127-8*byte_cnt -: 8]` ← `sw_in`, then `byte_cnt`++.
  - When `byte_cnt` becomes 16, go to READY.
- READY: `start`=1, `full`=1, `data` frozen. On `press`, go to ISSUE.
- ISSUE: `action`=1 for exactly one cycle, then unconditionally go to DONE.
- DONE:
  - `start`=1, `data` held stable for the `md5_output` computation.
  - `press`: `data`←0, `byte_cnt`←0, go to COLLECT.
- `sw_in` changes outside a `press` cycle have no effect.

Boundary conditions:
- `clear_in` high at any edge: same effect as reset except the debouncer keeps its state. `clear_in` wins over a simultaneous `press`.
- `rst` low mid-operation, including during ISSUE: `action` drops on that edge and no strobe is emitted.
- A `press` in READY does not write a 17th byte; the byte count never wraps.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no `press`.
- A key held down produces exactly one `press`.

## Timing
- After a clean `key_in` fall, `data`/`byte_cnt` update on the `DEBOUNCE_CYCLES+3`th rising edge (2 sync, `DEBOUNCE_CYCLES` count, 1 write).
- `start` and `full` rise on the same edge that `byte_cnt` becomes 16.
- `action` is high for exactly one cycle, `DEBOUNCE_CYCLES+4` edges after the launching key fall (one cycle in READY→ISSUE).
- `data` is stable from the edge `start` rises until the edge that leaves DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `md5_pkg`:
  - `MSG_BYTES` constant.
  - Loader state enum: COLLECT, READY, ISSUE, DONE.
  - `MD5_DIGEST_W`=128. `md5_output` uses the same package.
- One sub-module, `key_debounce` (synchronizer, counter, press pulse), parameterized by `DEBOUNCE_CYCLES`; reused for other board buttons.
- Top level holds the state machine, byte counter and data register.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4.
- Reset then idle 20 cycles → all outputs 0, `byte_cnt`=0.
- Enter the bytes 0x61..0x70 with clean presses → `data`=128'h6162636465666768696a6b6c6d6e6f70; `start`=`full`=1 on the same edge as `byte_cnt`=16; each byte lands exactly 7 edges after its key fall.
- From READY, press → `action` high exactly one cycle, 8 edges after the fall; `data` unchanged through DONE; the next press → `data`=0, `byte_cnt`=0.
- Bounce `key_in` low for 3 cycles, five times, then hold low 10 cycles → exactly one byte loaded; holding 1000 cycles still loads one.
- Load 9 bytes, then assert `clear_in` in the same cycle as a `press` → `byte_cnt`=0, `data`=0, no write.
- Assert `rst` low during the ISSUE cycle → `action`=0 from that edge; state COLLECT; no strobe observed.
- With 16 bytes loaded of 0xFF, press in READY → `byte_cnt` stays 16 and `data` is still all-ones.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 board demo: message geometry and loader state encoding.
package md5_pkg;

    localparam int MSG_BYTES    = 16;
    localparam int MD5_DIGEST_W = 128;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        READY   = 2'd1,
        ISSUE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted press (debounced 1->0 transition of an active-low key).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [CW-1:0] cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle;
    // only a flip away from the released level (stable was 1) is a press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= key_in;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt    <= '0;
                stable <= sync_b;
                press  <= stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/md5_msg_loader.sv
// Collects a message one switch byte per key press, presents it to md5_output
// and fires a one-cycle launch strobe on the press after the message is complete.
module md5_msg_loader
    import md5_pkg::*;
#(
    parameter int MSG_BYTES       = md5_pkg::MSG_BYTES,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       sw_in,
    input  logic                             key_in,
    input  logic                             clear_in,
    output logic [8*MSG_BYTES-1:0]           data,
    output logic                             start,
    output logic                             action,
    output logic [$clog2(MSG_BYTES+1)-1:0]   byte_cnt,
    output logic                             full
);

    localparam int CNT_W = $clog2(MSG_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MSG_BYTES - 1);

    logic          press;
    loader_state_t state;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk   (clk),
        .rst   (rst),
        .key_in(key_in),
        .press (press)
    );

    // clear_in shares the reset path but leaves the debouncer alone, so a key
    // still held across a clear is not seen as a fresh press.
    always_ff @(posedge clk) begin
        if (!rst || clear_in) begin
            state    <= COLLECT;
            data     <= '0;
            byte_cnt <= '0;
            start    <= 1'b0;
            full     <= 1'b0;
            action   <= 1'b0;
        end else begin
            action <= 1'b0;
            case (state)
                COLLECT: begin
                    if (press) begin
                        for (int i = 0; i < MSG_BYTES; i++) begin
                            if (byte_cnt == CNT_W'(i)) begin
                                data[8*(MSG_BYTES-1-i) +: 8] <= sw_in;
                            end
                        end
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_SLOT) begin
                            state <= READY;
                            start <= 1'b1;
                            full  <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (press) begin
                        state <= ISSUE;
                    end
                end
                // Strobe is raised on the edge leaving ISSUE, so a reset during
                // ISSUE suppresses it entirely.
                ISSUE: begin
                    action <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (press) begin
                        state    <= COLLECT;
                        data     <= '0;
                        byte_cnt <= '0;
                        start    <= 1'b0;
                        full     <= 1'b0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
